// File: rtl/traffic_light_fsm_pkg.sv
// Shared state encoding, lamp codes and timer-value width for the intersection controller.
// Combinational helpers only. No state and no flow control.
package traffic_light_fsm_pkg;

    localparam int TV_W = 4;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    typedef enum logic [2:0] {
        MG   = 3'd0,
        MGX  = 3'd1,
        MY   = 3'd2,
        SG   = 3'd3,
        SY   = 3'd4,
        WALK = 3'd5
    } state_t;

    // Returns {main_light, side_light} for a state; unknown encodings show all-red.
    function automatic logic [5:0] lamps_of(input state_t s);
        case (s)
            MG, MGX: return {LAMP_G, LAMP_R};
            MY:      return {LAMP_Y, LAMP_R};
            SG:      return {LAMP_R, LAMP_G};
            SY:      return {LAMP_R, LAMP_Y};
            default: return {LAMP_R, LAMP_R};
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_fsm_req_latch.sv
// Request latch: set by a level/pulse, cleared on a chosen state entry (clear wins).
// One-cycle latency from set/clr to q. No backpressure.
module traffic_light_fsm_req_latch (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (set) q_d = 1'b1;
        if (clr) q_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= 1'b0;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/traffic_light_fsm.sv
// Intersection sequencer: drives lamps and arms the interval timer on every state entry.
// Accepted expiry at edge N shows the new state after edge N+1. Expiry is ignored for 3 cycles after each arm.
module traffic_light_fsm
    import traffic_light_fsm_pkg::*;
#(
    parameter int unsigned T_BASE = 6,
    parameter int unsigned T_EXT  = 3,
    parameter int unsigned T_YEL  = 2
) (
    input  logic            clk,
    input  logic            Reset_Sync,
    input  logic            sensor,
    input  logic            walk_request,
    input  logic            expired,
    output logic            start_timer,
    output logic [TV_W-1:0] value,
    output logic [2:0]      main_light,
    output logic [2:0]      side_light,
    output logic            walk_lamp
);

    if (T_BASE < 1 || T_BASE > 15 || T_EXT < 1 || T_EXT > 15 || T_YEL < 1 || T_YEL > 15) begin : g_bad_param
        $error("traffic_light_fsm: interval parameters must be in 1..15");
    end

    localparam logic [1:0] GUARD = 2'd3;

    function automatic logic [TV_W-1:0] value_of(input state_t s);
        case (s)
            MGX, WALK: return TV_W'(T_EXT);
            MY, SY:    return TV_W'(T_YEL);
            default:   return TV_W'(T_BASE);
        endcase
    endfunction

    state_t          state_q, state_d, nxt_state;
    logic            start_timer_q, start_timer_d;
    logic [TV_W-1:0] value_q, value_d;
    logic [2:0]      main_light_q, main_light_d;
    logic [2:0]      side_light_q, side_light_d;
    logic            walk_lamp_q, walk_lamp_d;
    logic            rearm_q, rearm_d;
    logic            go_q, go_d;
    logic [1:0]      guard_q, guard_d;
    logic            illegal, enter;
    logic            sensor_reg, walk_reg;

    always_comb begin
        state_d       = state_q;
        start_timer_d = 1'b0;
        value_d       = value_q;
        main_light_d  = main_light_q;
        side_light_d  = side_light_q;
        walk_lamp_d   = walk_lamp_q;
        rearm_d       = 1'b0;
        guard_d       = (guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0;
        illegal       = 1'b0;
        enter         = 1'b0;
        nxt_state     = MG;

        case (state_q)
            MG:      nxt_state = sensor_reg ? MGX : MY;
            MGX:     nxt_state = MY;
            MY:      nxt_state = walk_reg ? WALK : SG;
            WALK:    nxt_state = SG;
            SG:      nxt_state = SY;
            SY:      nxt_state = MG;
            default: illegal   = 1'b1;
        endcase

        // go_q holds the accepted expiry for one cycle so latches set on the same edge are honoured.
        go_d = expired && (guard_q == 2'd0) && !go_q && !rearm_q && !illegal;

        if (rearm_q) begin
            start_timer_d = 1'b1;
            guard_d       = GUARD;
        end else if (go_q || illegal) begin
            enter                        = 1'b1;
            state_d                      = nxt_state;
            start_timer_d                = 1'b1;
            guard_d                      = GUARD;
            value_d                      = value_of(nxt_state);
            {main_light_d, side_light_d} = lamps_of(nxt_state);
            walk_lamp_d                  = (nxt_state == WALK);
        end
    end

    always_ff @(posedge clk) begin
        if (Reset_Sync) begin
            state_q       <= MG;
            start_timer_q <= 1'b0;
            value_q       <= TV_W'(T_BASE);
            main_light_q  <= LAMP_G;
            side_light_q  <= LAMP_R;
            walk_lamp_q   <= 1'b0;
            rearm_q       <= 1'b1;
            go_q          <= 1'b0;
            guard_q       <= GUARD;
        end else begin
            state_q       <= state_d;
            start_timer_q <= start_timer_d;
            value_q       <= value_d;
            main_light_q  <= main_light_d;
            side_light_q  <= side_light_d;
            walk_lamp_q   <= walk_lamp_d;
            rearm_q       <= rearm_d;
            go_q          <= go_d;
            guard_q       <= guard_d;
        end
    end

    traffic_light_fsm_req_latch u_sensor_latch (
        .clk (clk),
        .rst (Reset_Sync),
        .set (sensor && (state_q == MG)),
        .clr (enter && (nxt_state == MGX || nxt_state == MY)),
        .q   (sensor_reg)
    );

    traffic_light_fsm_req_latch u_walk_latch (
        .clk (clk),
        .rst (Reset_Sync),
        .set (walk_request),
        .clr (enter && (nxt_state == WALK)),
        .q   (walk_reg)
    );

    assign start_timer = start_timer_q;
    assign value       = value_q;
    assign main_light  = main_light_q;
    assign side_light  = side_light_q;
    assign walk_lamp   = walk_lamp_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: timer model plus a scoreboard of expected state entries.
module tb_traffic_light_fsm;

    localparam int TICK = 10;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam int S_MG = 0, S_MGX = 1, S_MY = 2, S_SG = 3, S_SY = 4, S_WALK = 5;

    logic       clk = 1'b0;
    logic       Reset_Sync = 1'b1;
    logic       sensor = 1'b0;
    logic       walk_request = 1'b0;
    logic       expired;
    logic       start_timer;
    logic [3:0] value;
    logic [2:0] main_light, side_light;
    logic       walk_lamp;

    traffic_light_fsm dut (
        .clk          (clk),
        .Reset_Sync   (Reset_Sync),
        .sensor       (sensor),
        .walk_request (walk_request),
        .expired      (expired),
        .start_timer  (start_timer),
        .value        (value),
        .main_light   (main_light),
        .side_light   (side_light),
        .walk_lamp    (walk_lamp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] value;
        logic [2:0] ml;
        logic [2:0] sl;
        logic       wl;
        int         gap;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    // Timer model: expires `value` ticks after start, then again on every tick.
    int   tmr_cnt = 15;
    int   tick_cnt = 0;
    logic tmr_exp = 1'b0;
    logic force_exp = 1'b0;
    logic rnd_exp = 1'b0;
    assign expired = tmr_exp | force_exp | rnd_exp;

    always @(negedge clk) begin
        tmr_exp = 1'b0;
        if (start_timer === 1'b1) begin
            tmr_cnt  = int'(value);
            tick_cnt = 0;
        end else begin
            tick_cnt++;
            if (tick_cnt == TICK) begin
                tick_cnt = 0;
                if (tmr_cnt > 0) tmr_cnt--;
                if (tmr_cnt == 0) tmr_exp = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on each start pulse and tracks invariants.
    int         cyc = 0;
    int         last_start = 0;
    bit         sb_en = 1'b1;
    int         viol = 0;
    int         walk_seen = 0;
    logic [3:0] prev_value = 4'd0;
    logic       prev_start = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (Reset_Sync === 1'b0) begin
            if (!$onehot(main_light) || !$onehot(side_light)) viol++;
            if (main_light !== R && side_light !== R) viol++;
            if (walk_lamp === 1'b1 && (main_light !== R || side_light !== R)) viol++;
            if (value !== prev_value && start_timer !== 1'b1) viol++;
            if (start_timer === 1'b1 && prev_start === 1'b1) viol++;
            if (walk_lamp === 1'b1) walk_seen++;
        end
        if (sb_en && start_timer === 1'b1) begin
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_entry: got value=%0d main=%b side=%b walk=%b, required no entry", value, main_light, side_light, walk_lamp);
            end else begin
                e = sb_q.pop_front();
                if ({value, main_light, side_light, walk_lamp} !== {e.value, e.ml, e.sl, e.wl}) begin
                    tests_failed++;
                    $display("FAIL entry: got value=%0d main=%b side=%b walk=%b, required value=%0d main=%b side=%b walk=%b",
                             value, main_light, side_light, walk_lamp, e.value, e.ml, e.sl, e.wl);
                end
                if (e.gap != 0) begin
                    tests_run++;
                    if (cyc - last_start != e.gap) begin
                        tests_failed++;
                        $display("FAIL entry_gap: got %0d cycles, required %0d", cyc - last_start, e.gap);
                    end
                end
            end
        end
        if (start_timer === 1'b1) last_start = cyc;
        prev_value = value;
        prev_start = start_timer;
    end

    task automatic push(input int st, input int gap);
        exp_t e;
        e.gap = gap;
        e.wl  = 1'b0;
        case (st)
            S_MG:    begin e.value = 4'd6; e.ml = G; e.sl = R; end
            S_MGX:   begin e.value = 4'd3; e.ml = G; e.sl = R; end
            S_MY:    begin e.value = 4'd2; e.ml = Y; e.sl = R; end
            S_SG:    begin e.value = 4'd6; e.ml = R; e.sl = G; end
            S_SY:    begin e.value = 4'd2; e.ml = R; e.sl = Y; end
            default: begin e.value = 4'd3; e.ml = R; e.sl = R; e.wl = 1'b1; end
        endcase
        sb_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d entries pending after %0d cycles, required 0", sb_q.size(), budget);
            sb_q.delete();
        end
    endtask

    task automatic wait_expired(input int budget);
        int n = 0;
        while (expired !== 1'b1 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        tests_run++;
        if (expired !== 1'b1) begin
            tests_failed++;
            $display("FAIL wait_expired: got no expiry in %0d cycles, required one", budget);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        Reset_Sync = 1'b1; sensor = 1'b0; walk_request = 1'b0; force_exp = 1'b0; rnd_exp = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        push(S_MG, 0);
        Reset_Sync = 1'b0;
        drain(4);
    endtask

    task automatic check_reset_outputs(input string tag);
        tests_run += 5;
        if (start_timer !== 1'b0) begin tests_failed++; $display("FAIL %s start_timer: got %b, required 0", tag, start_timer); end
        if (value !== 4'd6)       begin tests_failed++; $display("FAIL %s value: got %0d, required 6", tag, value); end
        if (main_light !== G)     begin tests_failed++; $display("FAIL %s main_light: got %b, required %b", tag, main_light, G); end
        if (side_light !== R)     begin tests_failed++; $display("FAIL %s side_light: got %b, required %b", tag, side_light, R); end
        if (walk_lamp !== 1'b0)   begin tests_failed++; $display("FAIL %s walk_lamp: got %b, required 0", tag, walk_lamp); end
    endtask

    task automatic test_reset();
        Reset_Sync = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        push(S_MG, 0);
        Reset_Sync = 1'b0;
        @(negedge clk); #1;
        tests_run++;
        if (start_timer !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_start: got %b, required 1", start_timer);
        end
        drain(2);
    endtask

    task automatic test_cycle();
        do_reset();
        push(S_MY, 0); push(S_SG, 0); push(S_SY, 0); push(S_MG, 0);
        drain(400);
    endtask

    task automatic test_sensor();
        do_reset();
        sensor = 1'b1;
        @(negedge clk); #1;
        sensor = 1'b0;
        push(S_MGX, 0); push(S_MY, 0); push(S_SG, 0); push(S_SY, 0); push(S_MG, 0); push(S_MY, 0);
        drain(600);
    endtask

    task automatic test_walk();
        do_reset();
        push(S_MY, 0); push(S_SG, 0);
        drain(300);
        walk_request = 1'b1;
        @(negedge clk); #1;
        walk_request = 1'b0;
        push(S_SY, 0); push(S_MG, 0); push(S_MY, 0); push(S_WALK, 0); push(S_SG, 0);
        push(S_SY, 0); push(S_MG, 0); push(S_MY, 0); push(S_SG, 0);
        drain(1000);
    endtask

    task automatic test_arm_guard();
        do_reset();
        force_exp = 1'b1;
        push(S_MY, 5); push(S_SG, 5); push(S_SY, 5); push(S_MG, 5); push(S_MY, 5);
        drain(60);
        force_exp = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        wait_expired(100);
        sensor = 1'b1;
        @(negedge clk); #1;
        sensor = 1'b0;
        push(S_MGX, 0); push(S_MY, 0);
        drain(200);
        wait_expired(100);
        walk_request = 1'b1;
        @(negedge clk); #1;
        walk_request = 1'b0;
        push(S_WALK, 0); push(S_SG, 0);
        drain(200);
    endtask

    task automatic test_reset_mid_sg();
        do_reset();
        push(S_MY, 0); push(S_SG, 0);
        drain(300);
        repeat (20) @(negedge clk);
        #1;
        Reset_Sync = 1'b1;
        @(negedge clk); #1;
        check_reset_outputs("mid_sg");
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (start_timer !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_sg_hold_start: got %b, required 0", start_timer);
        end
        push(S_MG, 0);
        Reset_Sync = 1'b0;
        @(negedge clk); #1;
        tests_run++;
        if (start_timer !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_sg_release_start: got %b, required 1", start_timer);
        end
        drain(2);
        push(S_MY, 0);
        drain(200);
    endtask

    task automatic test_random();
        do_reset();
        sb_en = 1'b0;
        walk_seen = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk); #1;
            sensor       = ($urandom_range(0, 3) == 0);
            walk_request = ($urandom_range(0, 15) == 0);
            rnd_exp      = ($urandom_range(0, 19) == 0);
        end
        sensor = 1'b0; walk_request = 1'b0; rnd_exp = 1'b0;
        tests_run++;
        if (walk_seen == 0) begin
            tests_failed++;
            $display("FAIL random_walk_seen: got 0 walk cycles, required >0");
        end
    endtask

    initial begin
        test_reset();
        test_cycle();
        test_sensor();
        test_walk();
        test_arm_guard();
        test_simultaneous();
        test_reset_mid_sg();
        test_random();
        tests_run++;
        if (viol != 0) begin
            tests_failed++;
            $display("FAIL invariants: got %0d violations, required 0", viol);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
